// File: rtl/rv32_dmem_lsu.sv
// ---------------------------------------------------------------------------
// rv32_dmem_lsu
// Load/store unit between an RV32 pipeline and a single-port-style data
// memory with separate read/write word addresses and a one-cycle read
// latency. Handles byte/half/word loads (sign/zero extended) and stores;
// sub-word stores are done as read-modify-write so other lanes survive.
//
// Ports
//   clock, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready   : request handshake (ready only when idle)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata               : request fields, sampled at acceptance
//   rsp_valid, rsp_err,
//   rsp_rdata               : one-cycle completion pulse with status/data
//   dmem_rdaddress,
//   dmem_wraddress          : memory word addresses (registered)
//   dmem_wren, dmem_data    : memory write strobe and write word
//   dmem_q                  : memory read word, one clock after address
// ---------------------------------------------------------------------------
module rv32_dmem_lsu #(
  parameter int DMEM_ADDR_W = 13
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [31:0]            rsp_rdata,
  output logic [DMEM_ADDR_W-1:0] dmem_rdaddress,
  output logic [DMEM_ADDR_W-1:0] dmem_wraddress,
  output logic                   dmem_wren,
  output logic [31:0]            dmem_data,
  input  logic [31:0]            dmem_q
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_e;

  state_e                 state_q;
  logic                   we_q;
  logic [1:0]             size_q;
  logic                   uns_q;
  logic [1:0]             off_q;
  logic [DMEM_ADDR_W-1:0] waddr_q;
  logic [31:0]            wdata_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [31:0]            rsp_rdata_q;
  logic                   dmem_wren_q;
  logic [31:0]            dmem_data_q;
  logic                   misaligned;

  // Address bits above the memory window wrap around and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:DMEM_ADDR_W+2];

  // Extract the addressed lane from a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'd0;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Insert the right-aligned store data into its lane of the old memory word.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   r[7:0]   = wdata[7:0];
          2'b01:   r[15:8]  = wdata[7:0];
          2'b10:   r[23:16] = wdata[7:0];
          2'b11:   r[31:24] = wdata[7:0];
          default: r = old;
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Alignment check on the incoming request (size 11 is always rejected).
  always_comb begin
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Request sequencer: accepts in IDLE, walks the memory access, issues the response.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      waddr_q     <= '0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      dmem_wren_q <= 1'b0;
      dmem_data_q <= 32'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      dmem_wren_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[1:0];
            waddr_q <= req_addr[DMEM_ADDR_W+1:2];
            wdata_q <= req_wdata;
            if (misaligned) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= 32'd0;
            end else if (req_we && (req_size == 2'b10)) begin
              // Full-word store needs no read: write straight away.
              dmem_data_q <= req_wdata;
              dmem_wren_q <= 1'b1;
              state_q     <= WR;
            end else begin
              state_q <= RD_ADDR;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          if (we_q) begin
            dmem_data_q <= store_merge(dmem_q, wdata_q, size_q, off_q);
            dmem_wren_q <= 1'b1;
            state_q     <= WR;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= load_extend(dmem_q, size_q, off_q, uns_q);
            state_q     <= IDLE;
          end
        end
        WR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'd0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign dmem_rdaddress = waddr_q;
  assign dmem_wraddress = waddr_q;
  assign dmem_wren      = dmem_wren_q;
  assign dmem_data      = dmem_data_q;

endmodule
